lsu_mem_ctrl: RTL

- Memory-access stage that consumes the 12-bit byte address produced by the execute-stage ALU for LWI/SWI/LW/SW.
- Performs the data-memory read or write over a req/ack handshake.
- Returns load data plus a writeback request to the register file.
- Sits between the execute ALU and the data memory; it is the consumer/responder end of the ALU's address output.

---
 rtl/lsu_mem_ctrl_pkg.sv | 28 ++
 rtl/lsu_mem_ctrl_ls_op_decode.sv | 32 +++
 rtl/lsu_mem_ctrl.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/lsu_mem_ctrl_pkg.sv
// ============================================================================
// Module : lsu_mem_ctrl_pkg
// Brief  : Shared opcodes, sub-opcodes, widths and state encoding for the LSU.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package lsu_mem_ctrl_pkg;

    localparam int ADDR_W_DEF = 12;
    localparam int DATA_W_DEF = 32;

    localparam logic [5:0] OP_LWI     = 6'b000010;
    localparam logic [5:0] OP_SWI     = 6'b001010;
    localparam logic [5:0] OP_TYPE_LS = 6'b011100;

    localparam logic [7:0] SUB_LW = 8'b00000010;
    localparam logic [7:0] SUB_SW = 8'b00001010;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

endpackage

`default_nettype wire

// File: rtl/lsu_mem_ctrl_ls_op_decode.sv
// ============================================================================
// Module : ls_op_decode
// Brief  : Combinational load/store classification; major opcode wins.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ls_op_decode
    import lsu_mem_ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [7:0] sub_opcode_8bit,
    output logic       is_load,
    output logic       is_store
);

    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        if (opcode == OP_LWI) begin
            is_load = 1'b1;
        end else if (opcode == OP_SWI) begin
            is_store = 1'b1;
        end else if (opcode == OP_TYPE_LS) begin
            is_load  = (sub_opcode_8bit == SUB_LW);
            is_store = (sub_opcode_8bit == SUB_SW);
        end
    end

endmodule

`default_nettype wire

// File: rtl/lsu_mem_ctrl.sv
// ============================================================================
// Module : lsu_mem_ctrl
// Brief  : Memory-access stage: one req/ack data-memory access per op, load
//          writeback on completion. Optional macro MISALIGN_CHECK_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module lsu_mem_ctrl
    import lsu_mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int DM_AW  = ADDR_W - 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable_mem,
    input  logic [5:0]        opcode,
    input  logic [7:0]        sub_opcode_8bit,
    input  logic [ADDR_W-1:0] alu_result,
    input  logic [DATA_W-1:0] store_data,
    input  logic [4:0]        rt_index,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] load_data,
    output logic              wb_en,
    output logic [4:0]        wb_index,
    output logic              dm_req,
    output logic              dm_we,
    output logic [DM_AW-1:0]  dm_addr,
    output logic [DATA_W-1:0] dm_wdata,
    input  logic [DATA_W-1:0] dm_rdata,
    input  logic              dm_ack,
    output logic              misalign
);

    logic w_is_load;
    logic w_is_store;

    ls_op_decode u_decode (
        .opcode          (opcode),
        .sub_opcode_8bit (sub_opcode_8bit),
        .is_load         (w_is_load),
        .is_store        (w_is_store)
    );

    state_e            state_q,     state_d;
    logic              kind_load_q, kind_load_d;
    logic [DM_AW-1:0]  dm_addr_q,   dm_addr_d;
    logic [DATA_W-1:0] dm_wdata_q,  dm_wdata_d;
    logic [DATA_W-1:0] load_data_q, load_data_d;
    logic [4:0]        wb_index_q,  wb_index_d;
    logic              busy_q,      busy_d;
    logic              done_q,      done_d;
    logic              wb_en_q,     wb_en_d;
    logic              dm_req_q,    dm_req_d;
    logic              dm_we_q,     dm_we_d;
    logic              misalign_d;

    always_comb begin
        state_d     = state_q;
        kind_load_d = kind_load_q;
        dm_addr_d   = dm_addr_q;
        dm_wdata_d  = dm_wdata_q;
        load_data_d = load_data_q;
        wb_index_d  = wb_index_q;
        misalign_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (enable_mem && (w_is_load || w_is_store)) begin
                    kind_load_d = w_is_load;
                    dm_addr_d   = alu_result[ADDR_W-1:2];
                    dm_wdata_d  = store_data;
                    wb_index_d  = rt_index;
                    state_d     = ST_ACCESS;
`ifdef MISALIGN_CHECK_EN
                    if (alu_result[1:0] != 2'b00) begin
                        state_d    = ST_RESP;
                        misalign_d = 1'b1;
                    end
`endif
                end
            end
            ST_ACCESS: begin
                if (dm_ack) begin
                    if (kind_load_q) begin
                        load_data_d = dm_rdata;
                    end
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // All handshake outputs are registered images of the next state.
        busy_d   = (state_d != ST_IDLE);
        done_d   = (state_d == ST_RESP);
        wb_en_d  = (state_d == ST_RESP) && kind_load_d && !misalign_d;
        dm_req_d = (state_d == ST_ACCESS);
        dm_we_d  = (state_d == ST_ACCESS) && !kind_load_d;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            kind_load_q <= 1'b0;
            dm_addr_q   <= '0;
            dm_wdata_q  <= '0;
            load_data_q <= '0;
            wb_index_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            wb_en_q     <= 1'b0;
            dm_req_q    <= 1'b0;
            dm_we_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            kind_load_q <= kind_load_d;
            dm_addr_q   <= dm_addr_d;
            dm_wdata_q  <= dm_wdata_d;
            load_data_q <= load_data_d;
            wb_index_q  <= wb_index_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            wb_en_q     <= wb_en_d;
            dm_req_q    <= dm_req_d;
            dm_we_q     <= dm_we_d;
        end
    end

`ifdef MISALIGN_CHECK_EN
    logic misalign_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
        end
    end

    assign misalign = misalign_q;
`else
    // Low address bits are dropped when the check is compiled out.
    logic w_unused_lo;
    assign w_unused_lo = ^{alu_result[1:0], misalign_d};
    assign misalign    = 1'b0;
`endif

    assign busy      = busy_q;
    assign done      = done_q;
    assign load_data = load_data_q;
    assign wb_en     = wb_en_q;
    assign wb_index  = wb_index_q;
    assign dm_req    = dm_req_q;
    assign dm_we     = dm_we_q;
    assign dm_addr   = dm_addr_q;
    assign dm_wdata  = dm_wdata_q;

endmodule

`default_nettype wire
